// File: rtl/ram_bit_insert_unit_16_pkg.sv
// Shared types and helpers for the bit-insert word builder: FSM encoding,
// default geometry and a saturating counter increment.
package ram_bit_insert_unit_16_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_WIDTH  = 16;
  localparam int DEFAULT_REG_WIDTH   = 4;
  localparam int DEFAULT_COUNT_WIDTH = 5;

  // Increment value, sticking at the largest number a width-bit counter holds.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input int unsigned width);
    logic [31:0] max_val;
    max_val = (32'd1 << width) - 32'd1;
    return (value >= max_val) ? max_val : value + 32'd1;
  endfunction

endpackage

// File: rtl/ram_bit_insert_core.sv
// Combinational single-bit insert: replaces word[index] with value when enabled
// and the index lies inside the word. Write-side mirror of the bit-select mux.
module ram_bit_insert_core #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_WIDTH  = 4
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [REG_WIDTH-1:0]  index,
  input  logic                  value,
  input  logic                  en,
  output logic [DATA_WIDTH-1:0] new_word,
  output logic                  in_range
);

  localparam logic [31:0] DW = DATA_WIDTH;

  assign in_range = (32'(index) < DW);

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    new_word = word;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (en && (index == REG_WIDTH'(i))) new_word[i] = value;
    end
  end

endmodule

// File: rtl/ram_bit_insert_unit_16.sv
// Builds a word from a loaded base plus (index, value) bit writes and hands it
// out on a valid/ready port. Ready/valid flags are registered state decodes.
module ram_bit_insert_unit_16
  import ram_bit_insert_unit_16_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int REG_WIDTH   = DEFAULT_REG_WIDTH,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_valid,
  input  logic [DATA_WIDTH-1:0]  load_data,
  output logic                   load_ready,
  input  logic                   bit_valid,
  input  logic [REG_WIDTH-1:0]   bit_index,
  input  logic                   bit_value,
  input  logic                   bit_last,
  output logic                   bit_ready,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  input  logic                   out_ready,
  output logic [COUNT_WIDTH-1:0] bit_count,
  output logic                   index_err
);

  state_t                state, next_state;
  logic [DATA_WIDTH-1:0] word, new_word;
  logic                  in_range;
  logic                  load_fire, bit_fire, out_fire;
  logic                  load_ready_d, bit_ready_d, out_valid_d;

  // Ready flags are registered, so a masked valid can never fire in the
  // wrong state even if the other side drives unknowns there.
  assign load_fire = load_valid && load_ready;
  assign bit_fire  = bit_valid && bit_ready;
  assign out_fire  = out_valid && out_ready;

  ram_bit_insert_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .REG_WIDTH (REG_WIDTH)
  ) u_core (
    .word    (word),
    .index   (bit_index),
    .value   (bit_value),
    .en      (bit_fire),
    .new_word(new_word),
    .in_range(in_range)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      load_ready <= 1'b0;
      bit_ready  <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      state      <= next_state;
      load_ready <= load_ready_d;
      bit_ready  <= bit_ready_d;
      out_valid  <= out_valid_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (load_fire) next_state = ACCUM;
      ACCUM:   if (bit_fire && bit_last) next_state = OUT;
      OUT:     if (out_fire) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Flags are decoded from the state being entered, which makes them
  // registered copies of the current state one edge later.
  always_comb begin
    load_ready_d = (next_state == IDLE);
    bit_ready_d  = (next_state == ACCUM);
    out_valid_d  = (next_state == OUT);
  end

  // NOTE: the word buffer is a plain register, not a memory, so it is
  // cleared by reset along with the rest of the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word      <= '0;
      out_data  <= '0;
      bit_count <= '0;
      index_err <= 1'b0;
    end else begin
      index_err <= bit_fire && !in_range;
      if (load_fire) begin
        word      <= load_data;
        bit_count <= '0;
      end else if (bit_fire) begin
        word <= new_word;
        if (in_range) bit_count <= COUNT_WIDTH'(sat_inc(32'(bit_count), COUNT_WIDTH));
        if (bit_last) out_data <= new_word;
      end
    end
  end

endmodule

// File: tb/tb_ram_bit_insert_unit_16.sv
// Randomised scoreboard bench for ram_bit_insert_unit_16, plus a 12-bit
// instance for out-of-range index handling.
module tb_ram_bit_insert_unit_16;

  localparam int CMAX = 31;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        load_valid, load_ready, bit_valid, bit_value, bit_last, bit_ready;
  logic        out_valid, out_ready, index_err;
  logic [15:0] load_data, out_data;
  logic [3:0]  bit_index;
  logic [4:0]  bit_count;

  logic        s_load_valid, s_load_ready, s_bit_valid, s_bit_value, s_bit_last, s_bit_ready;
  logic        s_out_valid, s_out_ready, s_index_err;
  logic [11:0] s_load_data, s_out_data;
  logic [3:0]  s_bit_index;
  logic [4:0]  s_bit_count;

  ram_bit_insert_unit_16 dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .bit_valid(bit_valid), .bit_index(bit_index), .bit_value(bit_value),
    .bit_last(bit_last), .bit_ready(bit_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .bit_count(bit_count), .index_err(index_err)
  );

  ram_bit_insert_unit_16 #(.DATA_WIDTH(12), .REG_WIDTH(4), .COUNT_WIDTH(5)) dut12 (
    .clk(clk), .rst_n(rst_n),
    .load_valid(s_load_valid), .load_data(s_load_data), .load_ready(s_load_ready),
    .bit_valid(s_bit_valid), .bit_index(s_bit_index), .bit_value(s_bit_value),
    .bit_last(s_bit_last), .bit_ready(s_bit_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(s_out_ready),
    .bit_count(s_bit_count), .index_err(s_index_err)
  );

  typedef struct {
    logic [15:0] data;
    logic [4:0]  count;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        got_e;
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_word;
  int          exp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: samples 1 time unit after the falling edge, pops on handshake,
  // and checks the word stays frozen while the consumer stalls.
  logic        hold_pending = 1'b0;
  logic [15:0] held_data;
  logic [4:0]  held_cnt;

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else if (out_valid) begin
      if (hold_pending) begin
        check("hold_data", out_data, held_data);
        check("hold_count", bit_count, held_cnt);
      end
      if (out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          got_e = sb_q.pop_front();
          check("out_data", out_data, got_e.data);
          check("out_count", bit_count, got_e.count);
        end
        hold_pending = 1'b0;
      end else begin
        hold_pending = 1'b1;
        held_data    = out_data;
        held_cnt     = bit_count;
      end
    end
  end

  task automatic send_load(input logic [15:0] d);
    int n = 0;
    load_valid = 1'b1;
    load_data  = d;
    while (!load_ready && n < 20) begin @(negedge clk); n++; end
    check("load_wait_timeout", n >= 20, 0);
    @(negedge clk);
    load_valid = 1'b0;
    load_data  = 16'($urandom);
    exp_word   = d;
    exp_cnt    = 0;
    check("bit_ready_after_load", bit_ready, 1);
    check("count_after_load", bit_count, 0);
  endtask

  task automatic send_bit(input int idx, input logic val, input logic last);
    int n = 0;
    // Reference model: later write wins, every in-range write counted.
    if (val) exp_word = exp_word | (16'h1 << idx);
    else     exp_word = exp_word & ~(16'h1 << idx);
    exp_cnt = (exp_cnt < CMAX) ? exp_cnt + 1 : CMAX;
    if (last) sb_q.push_back('{exp_word, 5'(exp_cnt)});
    bit_valid = 1'b1;
    bit_index = 4'(idx);
    bit_value = val;
    bit_last  = last;
    while (!bit_ready && n < 20) begin @(negedge clk); n++; end
    check("bit_wait_timeout", n >= 20, 0);
    @(negedge clk);
    bit_valid = 1'b0;
    bit_last  = 1'b0;
    check("bit_count", bit_count, exp_cnt);
    check("index_err_quiet", index_err, 0);
    if (last) check("out_latency", out_valid, 1);
  endtask

  task automatic finish_word(input int hold);
    int n = 0;
    while (!out_valid && n < 10) begin @(negedge clk); n++; end
    check("out_wait_timeout", n >= 10, 0);
    check("ready_in_out", {load_ready, bit_ready}, 0);
    for (int i = 0; i < hold; i++) begin
      load_valid = 1'b1;
      load_data  = 16'($urandom);
      bit_valid  = 1'b1;
      bit_index  = 4'($urandom);
      bit_value  = 1'($urandom);
      bit_last   = 1'b1;
      out_ready  = 1'b0;
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_ready", {load_ready, bit_ready}, 0);
    end
    load_valid = 1'b0;
    bit_valid  = 1'b0;
    bit_last   = 1'b0;
    out_ready  = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_drop", out_valid, 0);
    check("idle_after_out", load_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    load_valid = 0; load_data = 0; bit_valid = 0; bit_index = 0; bit_value = 0;
    bit_last = 0; out_ready = 0;
    s_load_valid = 0; s_load_data = 0; s_bit_valid = 0; s_bit_index = 0;
    s_bit_value = 0; s_bit_last = 0; s_out_ready = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_load_ready", load_ready, 0);
    check("rst_flags", {bit_ready, out_valid, index_err}, 0);
    check("rst_data", out_data, 0);
    check("rst_count", bit_count, 0);
    rst_n = 1'b1;
    check("release_no_edge", load_ready, 0);
    @(negedge clk);
    check("release_ready", load_ready, 1);

    // Directed words
    send_load(16'h0000);
    send_bit(3, 1'b1, 1'b0);
    send_bit(15, 1'b1, 1'b1);
    finish_word(0);

    send_load(16'hFFFF);
    send_bit(0, 1'b0, 1'b0);
    send_bit(0, 1'b1, 1'b0);
    send_bit(7, 1'b0, 1'b1);
    finish_word(5);

    // Random words with random consumer stalls
    for (int w = 0; w < 20; w++) begin
      send_load(16'($urandom));
      nb = $urandom_range(1, 8);
      for (int i = 0; i < nb; i++)
        send_bit($urandom_range(0, 15), 1'($urandom_range(0, 1)), i == nb - 1);
      finish_word($urandom_range(0, 3));
    end

    // Counter saturation
    send_load(16'h1234);
    for (int i = 0; i < 40; i++)
      send_bit(i % 16, 1'($urandom_range(0, 1)), i == 39);
    finish_word(1);

    // Reset in the middle of accumulation
    send_load(16'hA5A5);
    for (int i = 0; i < 4; i++) send_bit(i, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_flags", {load_ready, bit_ready, out_valid, index_err}, 0);
    check("midrst_data", out_data, 0);
    check("midrst_count", bit_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_release_no_edge", load_ready, 0);
    @(negedge clk);
    check("midrst_ready", load_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_out", out_valid, 0);
    end

    // 12-bit instance: out-of-range index
    check("w12_load_ready", s_load_ready, 1);
    s_load_valid = 1'b1;
    s_load_data  = 12'h000;
    @(negedge clk);
    s_load_valid = 1'b0;
    check("w12_bit_ready", s_bit_ready, 1);
    s_bit_valid = 1'b1; s_bit_index = 4'd13; s_bit_value = 1'b1; s_bit_last = 1'b0;
    @(negedge clk);
    s_bit_valid = 1'b0;
    check("w12_err_pulse", s_index_err, 1);
    check("w12_err_count", s_bit_count, 0);
    @(negedge clk);
    check("w12_err_clear", s_index_err, 0);
    s_bit_valid = 1'b1; s_bit_index = 4'd11; s_bit_value = 1'b1; s_bit_last = 1'b1;
    @(negedge clk);
    s_bit_valid = 1'b0; s_bit_last = 1'b0;
    check("w12_out_valid", s_out_valid, 1);
    check("w12_out_data", s_out_data, 12'h800);
    check("w12_out_count", s_bit_count, 1);
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
    check("w12_out_drop", s_out_valid, 0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_bit_insert_unit_16.md
Name: ram_bit_insert_unit_16

Overview:
- Write-side counterpart of the bit-select RAM read path: builds a 16-bit word by inserting single bits at register-addressed positions.
- A base word is loaded, then any number of (index, value) bit writes are applied, and the finished word is presented on a valid/ready output port.
- Sits between the bit-serial number-conversion datapath and the word-wide RAM write port.

Parameters:
- DATA_WIDTH, 16, width of the assembled word.
- REG_WIDTH, 4, width of the bit-index register; must satisfy 2**REG_WIDTH >= DATA_WIDTH.
- COUNT_WIDTH, 5, width of the accepted-bit counter; saturates at 2**COUNT_WIDTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset.
- load_valid  in  1  base word offered.
- load_data  in  DATA_WIDTH  base word.
- load_ready  out  1  block accepts a base word.
- bit_valid  in  1  bit write offered.
- bit_index  in  REG_WIDTH  target bit position.
- bit_value  in  1  value to insert.
- bit_last  in  1  final bit write of this word.
- bit_ready  out  1  block accepts a bit write.
- out_valid  out  1  assembled word available.
- out_data  out  DATA_WIDTH  assembled word.
- out_ready  in  1  consumer takes the word.
- bit_count  out  COUNT_WIDTH  number of accepted in-range bit writes for the current word.
- index_err  out  1  one-cycle pulse when an out-of-range index is accepted.

Interface (already decided): one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - word, out_data, bit_count = 0.
  - load_ready = 0 during reset; it is 1 from the first edge after release.
  - bit_ready, out_valid, index_err = 0.
  - A reset in any state discards the word in progress; nothing is emitted.
- State outputs:
  - IDLE: load_ready=1.
  - ACCUM: bit_ready=1.
  - OUT: out_valid=1.
  - All three are registered, decoded from state only, and never depend combinationally on inputs.
- Transfers happen only on the rising edge where valid && ready.
- IDLE, load accepted:
  - word <= load_data; bit_count <= 0; next state ACCUM.
  - Bit latency: the first bit write can be accepted on the next cycle.
- ACCUM, bit accepted with bit_index < DATA_WIDTH:
  - word[bit_index] <= bit_value.
  - bit_count increments, saturating at max; no wrap.
- ACCUM, bit accepted with bit_index >= DATA_WIDTH (possible only when DATA_WIDTH < 2**REG_WIDTH):
  - No write and no count.
  - index_err pulses high for the following cycle.
- Repeated index: the later write wins and each write is counted.
- bit_last with the accepted bit:
  - The write is applied and the next state is OUT.
  - out_data is the updated word on the first OUT cycle.
  - Latency from final bit accept to out_valid: 1 cycle.
- OUT:
  - out_data and bit_count are held stable while out_valid=1 && out_ready=0.
  - On out_ready, the next state is IDLE and out_valid drops next cycle.
  - out_data keeps its last value (not cleared).
  - bit_count resets to 0 only on the next load.
- No back-to-back overlap: load_ready=0 in OUT. The minimum word period is load (1) + N bits + output (1) cycles.
- Ignored inputs:
  - bit_valid in IDLE/OUT and load_valid in ACCUM/OUT are ignored with no side effects.
  - In OUT, X on those inputs must not propagate.
- Zero-bit word: unsupported. A word always needs at least one bit write carrying bit_last. A pass-through uses a dummy write of the same bit value.

Decomposition:
- Shared package:
  - state enum (IDLE=2'd0, ACCUM=2'd1, OUT=2'd2; 2'd3 is illegal and recovers to IDLE).
  - DATA_WIDTH/REG_WIDTH defaults.
  - saturating-increment helper function.
- One sub-module, ram_bit_insert_core: combinational next-word logic (word, index, value, enable -> new word, in_range flag). It mirrors the read-side mux and is reusable by other widths.
- Control FSM and counters stay in the top module.

Test Plan:
- Reset, load 16'h0000, bits (3,1),(15,1 last), out_ready=1 -> out_data=16'h8008, bit_count=2, out_valid for exactly 1 cycle.
- Load 16'hFFFF, write (0,0),(0,1),(7,0 last) -> out_data=16'hFF7F, bit_count=3 (repeat index counted, later wins).
- Hold out_ready=0 for 5 cycles while driving load_valid=1 and bit_valid=1 -> out_valid and out_data stable, load_ready=0, bit_ready=0; release -> IDLE next cycle.
- Assert rst_n=0 mid-ACCUM after 4 bits, then release -> all outputs zero, load_ready=1 after one edge, no out_valid.
- DATA_WIDTH=12 instance: write index 13 -> index_err pulse, word and bit_count unchanged; then (11,1 last) on base 0 -> out_data=12'h800.
- 40 bit writes to one word with COUNT_WIDTH=5 -> bit_count saturates at 31, no wrap.
